// File: rtl/poly_voice_synth.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : poly_voice_synth
// Brief    : Multi-voice phase-accumulator synthesizer. Voices are mixed
//            one per cycle after each sample tick, the sum is saturated and
//            the result drives a glitch-free PWM DAC.
// Revision : 1.0 - initial release
// ============================================================================
module poly_voice_synth #(
  parameter int NUM_VOICES = 4,
  parameter int ACC_WIDTH  = 16,
  parameter int SAMPLE_DIV = 256,
  parameter int OUT_WIDTH  = 8,
  parameter int MIX_SHIFT  = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          cfg_we,
  input  logic [$clog2(NUM_VOICES):0]   cfg_addr,
  input  logic [ACC_WIDTH-1:0]          cfg_data,
  input  logic [NUM_VOICES-1:0]         voice_gate,
  output logic                          sample_tick,
  output logic                          sample_valid,
  output logic [OUT_WIDTH-1:0]          sample_out,
  output logic                          pwm_out
);

  localparam int c_VIDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam int c_MIX_W  = 8 + $clog2(NUM_VOICES) + 1;
  localparam int c_DIV_W  = $clog2(SAMPLE_DIV);
  localparam logic [31:0] c_OUT_MAX = 32'((64'd1 << OUT_WIDTH) - 64'd1);
  localparam logic [c_VIDX_W-1:0] c_LAST_VOICE = c_VIDX_W'(NUM_VOICES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_SAT  = 2'd2
  } state_t;

  state_t                 r_state;
  logic [c_DIV_W-1:0]     r_div_cnt;
  logic [ACC_WIDTH-1:0]   r_inc   [NUM_VOICES];
  logic [ACC_WIDTH-1:0]   r_phase [NUM_VOICES];
  logic [1:0]             r_wave  [NUM_VOICES];
  logic [3:0]             r_vol   [NUM_VOICES];
  logic [15:0]            r_lfsr;
  logic [c_VIDX_W-1:0]    r_idx;
  logic [c_MIX_W-1:0]     r_acc;
  logic [OUT_WIDTH-1:0]   r_pwm_cnt;
  logic [OUT_WIDTH-1:0]   r_pwm_cmp;

  logic [c_VIDX_W-1:0]    w_wr_voice;
  logic [7:0]             w_p;
  logic [7:0]             w_wave;
  logic [11:0]            w_prod;
  logic [7:0]             w_contrib;
  logic [c_MIX_W-1:0]     w_acc_sum;
  logic [31:0]            w_shift32;
  logic [OUT_WIDTH-1:0]   w_sat;

  // Voice index of a config write; a single-voice build has no index bits.
  generate
    if (NUM_VOICES > 1) begin : g_multi_voice
      assign w_wr_voice = cfg_addr[$clog2(NUM_VOICES):1];
    end else begin : g_single_voice
      assign w_wr_voice = 1'b0;
    end
  endgenerate

  // Sample-period divider; the tick is registered so it lands on count 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div_cnt   <= '0;
      sample_tick <= 1'b0;
    end else begin
      if (r_div_cnt == c_DIV_W'(SAMPLE_DIV - 1)) r_div_cnt <= '0;
      else                                       r_div_cnt <= r_div_cnt + 1'b1;
      sample_tick <= (r_div_cnt == c_DIV_W'(SAMPLE_DIV - 1));
    end
  end

  // Config registers and phase accumulators; a same-cycle increment write
  // is stored but the phase step still sees the old increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int v = 0; v < NUM_VOICES; v++) begin
        r_inc[v]   <= '0;
        r_phase[v] <= '0;
        r_wave[v]  <= 2'd0;
        r_vol[v]   <= 4'd0;
      end
    end else begin
      for (int v = 0; v < NUM_VOICES; v++) begin
        if (cfg_we && (w_wr_voice == c_VIDX_W'(v))) begin
          if (!cfg_addr[0]) begin
            r_inc[v] <= cfg_data;
          end else begin
            r_wave[v] <= cfg_data[1:0];
            r_vol[v]  <= cfg_data[5:2];
          end
        end
        if (sample_tick) r_phase[v] <= voice_gate[v] ? (r_phase[v] + r_inc[v]) : '0;
      end
    end
  end

  // Noise source, stepped once per sample period.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)              r_lfsr <= 16'hACE1;
    else if (sample_tick) r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
  end

  // Waveform and scaled contribution of the voice currently being mixed.
  always_comb begin
    w_p = r_phase[r_idx][ACC_WIDTH-1 -: 8];
    case (r_wave[r_idx])
      2'd0:    w_wave = {8{w_p[7]}};
      2'd1:    w_wave = w_p;
      2'd2:    w_wave = w_p[7] ? ~{w_p[6:0], 1'b0} : {w_p[6:0], 1'b0};
      default: w_wave = r_lfsr[7:0];
    endcase
    w_prod    = {4'd0, w_wave} * {8'd0, r_vol[r_idx]};
    w_contrib = voice_gate[r_idx] ? 8'(w_prod >> 4) : 8'd0;
    w_acc_sum = r_acc + c_MIX_W'(w_contrib);
    w_shift32 = 32'(w_acc_sum) >> MIX_SHIFT;
    w_sat     = (w_shift32 > c_OUT_MAX) ? '1 : OUT_WIDTH'(w_shift32);
  end

  // Mixer: one voice per cycle; the saturated result and its valid pulse are
  // registered on entry to SAT so they are visible during the SAT cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_idx        <= '0;
      r_acc        <= '0;
      sample_valid <= 1'b0;
      sample_out   <= '0;
    end else begin
      sample_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (sample_tick) begin
            r_acc   <= '0;
            r_idx   <= '0;
            r_state <= S_ACC;
          end
        end
        S_ACC: begin
          r_acc <= w_acc_sum;
          if (r_idx == c_LAST_VOICE) begin
            sample_out   <= w_sat;
            sample_valid <= 1'b1;
            r_state      <= S_SAT;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        S_SAT:   r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // PWM DAC; the compare value only changes as the counter wraps to 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pwm_cnt <= '0;
      r_pwm_cmp <= '0;
      pwm_out   <= 1'b0;
    end else begin
      r_pwm_cnt <= r_pwm_cnt + 1'b1;
      if (r_pwm_cnt == '1) r_pwm_cmp <= sample_out;
      pwm_out <= (r_pwm_cnt < r_pwm_cmp);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_poly_voice_synth.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_poly_voice_synth
// Brief    : Directed self-checking bench for poly_voice_synth.
// Revision : 1.0 - initial release
// ============================================================================
module tb_poly_voice_synth;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_we = 1'b0;
  logic [2:0]  cfg_addr = 3'd0;
  logic [15:0] cfg_data = 16'd0;
  logic [3:0]  voice_gate = 4'd0;
  logic        sample_tick;
  logic        sample_valid;
  logic [7:0]  sample_out;
  logic        pwm_out;

  int total  = 0;
  int passed = 0;

  always #5 clk = ~clk;

  poly_voice_synth dut (
    .clk          (clk),
    .rst          (rst),
    .cfg_we       (cfg_we),
    .cfg_addr     (cfg_addr),
    .cfg_data     (cfg_data),
    .voice_gate   (voice_gate),
    .sample_tick  (sample_tick),
    .sample_valid (sample_valid),
    .sample_out   (sample_out),
    .pwm_out      (pwm_out)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_tick(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!sample_tick && n < 600);
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!sample_valid && n < 50);
  endtask

  task automatic get_sample(output logic [7:0] s);
    int a;
    int b;
    wait_tick(a);
    wait_valid(b);
    s = (a >= 600 || b >= 50) ? 8'hxx : sample_out;
  endtask

  task automatic wr(input int v, input logic sel, input logic [15:0] d);
    @(negedge clk);
    cfg_we   = 1'b1;
    cfg_addr = {v[1:0], sel};
    cfg_data = d;
    @(negedge clk);
    cfg_we   = 1'b0;
  endtask

  initial begin
    logic [7:0] s;
    int n;
    int nv;
    int h;

    // Reset and tick timing
    repeat (5) @(negedge clk);
    chk("rst_tick", 32'(sample_tick), 0);
    chk("rst_valid", 32'(sample_valid), 0);
    chk("rst_sample", 32'(sample_out), 0);
    chk("rst_pwm", 32'(pwm_out), 0);
    rst = 1'b0;
    wait_tick(n);  chk("first_tick_lat", n, 256);
    wait_tick(n);  chk("tick_period", n, 256);
    wait_valid(n); chk("valid_lat", n, 5);
    chk("idle_sample", 32'(sample_out), 0);

    // Single square voice
    wr(0, 1'b0, 16'h8000);
    wr(0, 1'b1, 16'h003C);
    voice_gate = 4'b0001;
    get_sample(s); chk("sq_0", 32'(s), 119);
    get_sample(s); chk("sq_1", 32'(s), 0);
    get_sample(s); chk("sq_2", 32'(s), 119);

    // Gate release while sounding, then re-gate from a cleared phase
    voice_gate = 4'b0000;
    get_sample(s); chk("gate_release", 32'(s), 0);
    voice_gate = 4'b0001;
    get_sample(s); chk("regate_cleared", 32'(s), 119);

    // Increment written during the tick cycle applies one sample later
    wr(0, 1'b0, 16'h0000);
    get_sample(s); chk("inc_zero_hold", 32'(s), 119);
    wait_tick(n);
    cfg_we   = 1'b1;
    cfg_addr = 3'b000;
    cfg_data = 16'h8000;
    @(negedge clk);
    cfg_we   = 1'b0;
    wait_valid(n);
    chk("tick_write_old_inc", 32'(sample_out), 119);
    get_sample(s); chk("tick_write_new_inc", 32'(s), 0);
    voice_gate = 4'b0000;
    get_sample(s);

    // Saturation with all four voices
    for (int v = 0; v < 4; v++) begin
      wr(v, 1'b0, 16'h8000);
      wr(v, 1'b1, 16'h003C);
    end
    voice_gate = 4'b1111;
    get_sample(s); chk("sat_hi_0", 32'(s), 255);
    get_sample(s); chk("sat_lo", 32'(s), 0);
    get_sample(s); chk("sat_hi_1", 32'(s), 255);
    voice_gate = 4'b0000;
    get_sample(s); chk("sat_released", 32'(s), 0);

    // Saw ramp on voice 1
    wr(1, 1'b1, 16'h003D);
    wr(1, 1'b0, 16'h0100);
    voice_gate = 4'b0010;
    for (int k = 1; k <= 128; k++) begin
      get_sample(s);
      if (k == 1)   chk("saw_k1", 32'(s), 0);
      if (k == 16)  chk("saw_k16", 32'(s), 7);
      if (k == 64)  chk("saw_k64", 32'(s), 30);
      if (k == 128) chk("saw_k128", 32'(s), 60);
    end
    wr(1, 1'b0, 16'h1000);
    for (int k = 129; k <= 136; k++) begin
      get_sample(s);
      if (k == 135) chk("saw_p240", 32'(s), 112);
      if (k == 136) chk("saw_wrap", 32'(s), 0);
    end
    voice_gate = 4'b0000;
    get_sample(s);

    // Steady mid-scale sample for the PWM: saw p=19 (17) + square (239)
    wr(2, 1'b1, 16'h003D);
    wr(2, 1'b0, 16'h1300);
    wr(3, 1'b1, 16'h003C);
    wr(3, 1'b0, 16'h8000);
    voice_gate = 4'b1100;
    get_sample(s); chk("pwm_sample_0", 32'(s), 128);
    wr(2, 1'b0, 16'h0000);
    wr(3, 1'b0, 16'h0000);
    get_sample(s); chk("pwm_sample_1", 32'(s), 128);
    wait_tick(n);
    h = 0;
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      if (i == 0) chk("pwm_first_high", 32'(pwm_out), 1);
      if (pwm_out) h++;
    end
    chk("pwm_duty", h, 128);

    // Reset in the middle of a mix
    wait_tick(n);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_valid", 32'(sample_valid), 0);
    chk("midrst_sample", 32'(sample_out), 0);
    chk("midrst_pwm", 32'(pwm_out), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    n  = 0;
    nv = 0;
    do begin
      @(negedge clk);
      n++;
      if (sample_valid) nv++;
    end while (!sample_tick && n < 600);
    chk("midrst_no_valid", nv, 0);
    chk("midrst_tick_lat", n, 256);
    wait_valid(n); chk("midrst_valid_lat", n, 5);
    chk("midrst_vol_cleared", 32'(sample_out), 0);
    chk("midrst_pwm_low", 32'(pwm_out), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
